// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute control sequencer for the 16-register bank CPU.
// Outputs are decoded from state (and IR/mem_ready) and forced to idle values while rst is low.
module ctrl_sequencer #(
  parameter logic [3:0]  IDLE_SEL = 4'd15,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR_OP,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [3:0]  sel_ip,
  output logic [3:0]  sel_op,
  output logic        TRNSFR,
  output logic        en_pc,
  output logic        incpc,
  output logic        rstpc,
  output logic        ALUEN,
  output logic [3:0]  alu_func,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic        fault
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_ALU  = 3'd2;
  localparam logic [2:0] OP_LD   = 3'd3;
  localparam logic [2:0] OP_ST   = 3'd4;
  localparam logic [2:0] OP_JMP  = 3'd5;
  localparam logic [2:0] OP_JZ   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [3:0] R_PC     = 4'd0;
  localparam logic [3:0] R_AR     = 4'd1;
  localparam logic [3:0] R_ALUREG = 4'd2;
  localparam logic [3:0] R_IR     = 4'd3;
  localparam logic [3:0] R_D1     = 4'd4;
  localparam logic [3:0] R_D2     = 4'd5;
  localparam logic [3:0] R_R0     = 4'd6;

  typedef enum logic [3:0] {
    S_PCCLR, S_FETCH_AR, S_FETCH_MEM, S_INC_PC, S_DECODE, S_MOV1,
    S_ALU1, S_ALU2, S_ALU3, S_ALU4, S_ADDR1, S_LD2, S_ST2, S_HALT, S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic             z_flag_q, z_flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] op_c;
  logic [3:0] rd_c, rs_c, rt_c;
  logic       mem_state_c;

  assign op_c = IR_OP[15:13];
  assign rd_c = R_R0 + 4'(IR_OP[12:10]);
  assign rs_c = R_R0 + 4'(IR_OP[9:7]);
  assign rt_c = R_R0 + 4'(IR_OP[6:4]);
  assign mem_state_c = (state_q == S_FETCH_MEM) || (state_q == S_LD2) || (state_q == S_ST2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_PCCLR;
      z_flag_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      z_flag_q <= z_flag_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    z_flag_d = z_flag_q;
    cnt_d    = '0;
    sel_ip   = IDLE_SEL;
    sel_op   = 4'd0;
    TRNSFR   = 1'b0;
    en_pc    = 1'b0;
    incpc    = 1'b0;
    rstpc    = 1'b0;
    ALUEN    = 1'b0;
    alu_func = 4'd0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;

    case (state_q)
      S_PCCLR:     state_d = S_FETCH_AR;
      S_FETCH_AR:  state_d = S_FETCH_MEM;
      S_FETCH_MEM: if (mem_ready) state_d = S_INC_PC;
      S_INC_PC:    state_d = S_DECODE;
      S_DECODE: begin
        case (op_c)
          OP_NOP:                state_d = S_FETCH_AR;
          OP_MOV:                state_d = S_MOV1;
          OP_ALU:                state_d = S_ALU1;
          OP_LD, OP_ST, OP_JMP:  state_d = S_ADDR1;
          OP_JZ:                 state_d = z_flag_q ? S_ADDR1 : S_FETCH_AR;
          default:               state_d = S_HALT;
        endcase
      end
      S_MOV1: state_d = S_FETCH_AR;
      S_ALU1: state_d = S_ALU2;
      S_ALU2: state_d = S_ALU3;
      S_ALU3: begin
        z_flag_d = alu_zero;
        state_d  = S_ALU4;
      end
      S_ALU4:  state_d = S_FETCH_AR;
      S_ADDR1: begin
        if (op_c == OP_LD)      state_d = S_LD2;
        else if (op_c == OP_ST) state_d = S_ST2;
        else                    state_d = S_FETCH_AR;
      end
      S_LD2:   if (mem_ready) state_d = S_FETCH_AR;
      S_ST2:   if (mem_ready) state_d = S_FETCH_AR;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_PCCLR;
    endcase

    // Wait-cycle counter: a wait that would reach TIMEOUT aborts to FAULT.
    if (mem_state_c && !mem_ready) begin
      if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) state_d = S_FAULT;
      else                                       cnt_d   = cnt_q + CNT_W'(1);
    end

    if (rst) begin
      case (state_q)
        S_PCCLR: begin
          sel_ip = R_PC;
          en_pc  = 1'b1;
          rstpc  = 1'b1;
        end
        S_FETCH_AR: begin
          sel_op = R_PC;
          sel_ip = R_AR;
        end
        S_FETCH_MEM: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            sel_ip = R_IR;
            TRNSFR = 1'b1;
          end
        end
        S_INC_PC: begin
          sel_ip = R_PC;
          en_pc  = 1'b1;
          incpc  = 1'b1;
        end
        S_MOV1: begin
          sel_op = rs_c;
          sel_ip = rd_c;
        end
        S_ALU1: begin
          sel_op = rs_c;
          sel_ip = R_D1;
        end
        S_ALU2: begin
          sel_op = rt_c;
          sel_ip = R_D2;
        end
        S_ALU3: begin
          ALUEN    = 1'b1;
          alu_func = IR_OP[3:0];
        end
        S_ALU4: begin
          sel_op = R_ALUREG;
          sel_ip = rd_c;
        end
        S_ADDR1: begin
          sel_op = R_IR;
          if ((op_c == OP_LD) || (op_c == OP_ST)) begin
            sel_ip = R_AR;
          end else begin
            sel_ip = R_PC;
            en_pc  = 1'b1;
          end
        end
        S_LD2: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            sel_ip = R_R0;
            TRNSFR = 1'b1;
          end
        end
        S_ST2: begin
          mem_wr = 1'b1;
          sel_op = R_R0;
        end
        S_HALT:  halted = 1'b1;
        S_FAULT: fault  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
